fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one FIFO (fifoController plus its storage array) among N producers. Each cycle it selects at most one requesting producer, drives the FIFO write strobe and data from that producer, and returns a one-hot acknowledge. It sits between the producer blocks and the FIFO's `wr`/`w_data` inputs, and honours the FIFO's `full` flag so no write is ever dropped or issued while full.

---
 rtl/fifo_wr_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write-port arbiter that lets N producers share one FIFO. In any
// cycle it grants at most one requesting producer. For that producer it drives
// the FIFO write strobe and data, and it returns a one-hot acknowledge. The
// decode is purely combinational, so the FIFO samples the write on the same
// clock edge where the producer sees its ack. While fifo_full_i is high the
// arbiter never issues a write and holds all of its arbitration state.
//
// Build option:
//   FIFO_ARB_BURST_EN  When defined, a producer that wins in IDLE keeps the
//                      grant (LOCK state) for up to BURST_LEN consecutive
//                      writes. It loses the grant earlier if it drops its
//                      request; that release costs one bubble cycle. When
//                      undefined, every grant is a single write and BURST_LEN
//                      is ignored.
//
// Parameters:
//   N          number of producers (N >= 2)
//   DW         data width per producer
//   BURST_LEN  max consecutive writes per grant in the burst build (>= 1)
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   req_i         [N]     per-producer write request
//   wdata_i       [N*DW]  packed producer data, producer i at [i*DW +: DW]
//   fifo_full_i           FIFO full flag
//   ack_o         [N]     one-hot; producer i's word is written this cycle
//   fifo_wr_o             FIFO write strobe (= |ack_o)
//   fifo_wdata_o  [DW]    granted producer's data, zero when no write
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic [N*DW-1:0] wdata_i,
  input  logic            fifo_full_i,
  output logic [N-1:0]    ack_o,
  output logic            fifo_wr_o,
  output logic [DW-1:0]   fifo_wdata_o
);

  localparam int PW = $clog2(N);

  typedef logic [PW-1:0] idx_t;

  // Modulo-N increment. For non-power-of-two N, N-1 must wrap to 0 rather
  // than to the next register value.
  function automatic idx_t inc_mod(input idx_t x);
    if (x == idx_t'(N - 1)) return '0;
    else                    return x + idx_t'(1);
  endfunction

  // Return the first requesting index found when scanning ptr, ptr+1, ...
  // (mod N).
  function automatic void find_winner(input  idx_t       ptr,
                                      input  logic [N-1:0] req,
                                      output logic       found,
                                      output idx_t       win);
    int idx;
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx_t'(idx);
      end
    end
  endfunction

  idx_t ptr_q, ptr_d;
  logic found;
  idx_t winner;
  logic grant;
  idx_t grant_idx;

  // NOTE: every signal written in an always_comb block gets a default value
  // first. This means no path through the block leaves a signal unassigned,
  // so synthesis cannot infer a latch.
  always_comb begin
    find_winner(ptr_q, req_i, found, winner);
  end

`ifdef FIFO_ARB_BURST_EN

  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  idx_t            owner_q, owner_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  always_comb begin
    ptr_d     = ptr_q;
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    grant_idx = winner;

    // A full FIFO or an active reset freezes everything. The sequential
    // block applies the reset values.
    if (!reset && !fifo_full_i) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant     = 1'b1;
            grant_idx = winner;
            ptr_d     = inc_mod(winner);
            // With BURST_LEN = 1 the first write already completes the
            // burst, so the arbiter stays in IDLE. It behaves exactly like
            // the single-write build.
            if (BURST_LEN > 1) begin
              state_d = LOCK;
              owner_d = winner;
              cnt_d   = CW'(1);
            end
          end
        end
        LOCK: begin
          if (req_i[owner_q]) begin
            grant     = 1'b1;
            grant_idx = owner_q;
            if (cnt_q == CW'(BURST_LEN - 1)) begin
              state_d = IDLE;
              ptr_d   = inc_mod(owner_q);
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CW'(1);
            end
          end else begin
            // The owner abandoned its burst. Release the lock with no grant
            // in this cycle (a one-cycle bubble).
            state_d = IDLE;
            ptr_d   = inc_mod(owner_q);
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the values they held before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`else

  always_comb begin
    ptr_d     = ptr_q;
    grant     = 1'b0;
    grant_idx = winner;
    if (!reset && !fifo_full_i && found) begin
      grant = 1'b1;
      ptr_d = inc_mod(winner);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the values they held before the edge.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`endif

  // Output decode. Data is forced to zero when no write occurs, so the FIFO
  // bus never carries stale producer data.
  always_comb begin
    ack_o        = '0;
    fifo_wdata_o = '0;
    fifo_wr_o    = grant;
    if (grant) begin
      ack_o[grant_idx] = 1'b1;
      fifo_wdata_o     = wdata_i[int'(grant_idx)*DW +: DW];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Scoreboard bench for fifo_wr_arbiter. It uses two instances:
//   dut4: N = 4, BURST_LEN = 4. Runs the single-write vectors in the default
//         build and the burst vectors when FIFO_ARB_BURST_EN is defined.
//   dut3: N = 3, BURST_LEN = 1. Covers wrap-around for non-power-of-two N.
//         With BURST_LEN = 1 its grant sequence is the same in both builds.
// Stimulus tasks drive one cycle each and push the hand-computed expected
// ack/data onto a per-DUT queue. A separate monitor pops one entry per cycle
// on the falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] data;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;

  int checks   = 0;
  int failures = 0;

  // dut4 signals
  logic        rst4, full4, wr4;
  logic [3:0]  req4, ack4;
  logic [31:0] wd4;
  logic [7:0]  wdo4;

  // dut3 signals
  logic        rst3, full3, wr3;
  logic [2:0]  req3, ack3;
  logic [23:0] wd3;
  logic [7:0]  wdo3;

  assign wd4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  assign wd3 = {8'h32, 8'h31, 8'h30};

  fifo_wr_arbiter #(.N(4), .DW(8), .BURST_LEN(4)) dut4 (
    .clk          (clk),
    .reset        (rst4),
    .req_i        (req4),
    .wdata_i      (wd4),
    .fifo_full_i  (full4),
    .ack_o        (ack4),
    .fifo_wr_o    (wr4),
    .fifo_wdata_o (wdo4)
  );

  fifo_wr_arbiter #(.N(3), .DW(8), .BURST_LEN(1)) dut3 (
    .clk          (clk),
    .reset        (rst3),
    .req_i        (req3),
    .wdata_i      (wd3),
    .fifo_full_i  (full3),
    .ack_o        (ack3),
    .fifo_wr_o    (wr3),
    .fifo_wdata_o (wdo3)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle per call. Inputs change 1 time unit after the rising
  // edge, and the expected outputs for that cycle are queued.
  task automatic step4(input logic r, input logic [3:0] rq, input logic f,
                       input logic [3:0] ea, input logic [7:0] ed);
    @(posedge clk);
    #1;
    rst4  = r;
    req4  = rq;
    full4 = f;
    q4.push_back('{ack: ea, data: ed});
  endtask

  task automatic step3(input logic r, input logic [2:0] rq, input logic f,
                       input logic [2:0] ea, input logic [7:0] ed);
    @(posedge clk);
    #1;
    rst3  = r;
    req3  = rq;
    full3 = f;
    q3.push_back('{ack: {1'b0, ea}, data: ed});
  endtask

  // Monitor: compare outputs away from the active edge. If no entry is queued,
  // any write is unexpected.
  always @(negedge clk) begin
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      check("ack4",   {28'b0, ack4}, {28'b0, e4.ack});
      check("wr4",    {31'b0, wr4},  {31'b0, |e4.ack});
      check("wdata4", {24'b0, wdo4}, {24'b0, e4.data});
    end else if (wr4 !== 1'b0) begin
      check("idle_wr4", {31'b0, wr4}, 32'd0);
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      check("ack3",   {29'b0, ack3}, {28'b0, e3.ack});
      check("wr3",    {31'b0, wr3},  {31'b0, |e3.ack});
      check("wdata3", {24'b0, wdo3}, {24'b0, e3.data});
    end else if (wr3 !== 1'b0) begin
      check("idle_wr3", {31'b0, wr3}, 32'd0);
    end
  end

  initial begin
    rst4 = 1'b1; req4 = '0; full4 = 1'b0;
    rst3 = 1'b1; req3 = '0; full3 = 1'b0;
    repeat (2) @(posedge clk);

    // ---------------- dut4 ----------------
    // Reset with all requests up: outputs must be 0.
    step4(1, 4'b1111, 0, 4'b0000, 8'h00);
`ifdef FIFO_ARB_BURST_EN
    // Burst lock: producer 0 gets 4 writes, with a 2-cycle full stall
    // mid-burst.
    step4(0, 4'b0011, 0, 4'b0001, 8'hA0);
    step4(0, 4'b0011, 0, 4'b0001, 8'hA0);
    step4(0, 4'b0011, 1, 4'b0000, 8'h00);
    step4(0, 4'b0011, 1, 4'b0000, 8'h00);
    step4(0, 4'b0011, 0, 4'b0001, 8'hA0);
    step4(0, 4'b0011, 0, 4'b0001, 8'hA0);
    // Hand-over to producer 1 for a full burst.
    step4(0, 4'b0011, 0, 4'b0010, 8'hA1);
    step4(0, 4'b0011, 0, 4'b0010, 8'hA1);
    step4(0, 4'b0011, 0, 4'b0010, 8'hA1);
    step4(0, 4'b0011, 0, 4'b0010, 8'hA1);
    // Early release: producer 2 drops req after 2 writes -> bubble, then 3.
    step4(0, 4'b0100, 0, 4'b0100, 8'hA2);
    step4(0, 4'b0100, 0, 4'b0100, 8'hA2);
    step4(0, 4'b1001, 0, 4'b0000, 8'h00);
    step4(0, 4'b1001, 0, 4'b1000, 8'hA3);
    step4(0, 4'b1001, 0, 4'b1000, 8'hA3);
    // Reset mid-burst, then restart from ptr = 0.
    step4(1, 4'b1100, 0, 4'b0000, 8'h00);
    step4(0, 4'b1100, 0, 4'b0100, 8'hA2);
    step4(0, 4'b1100, 0, 4'b0100, 8'hA2);
`else
    // Round-robin over all four producers, wrapping back to 0.
    step4(0, 4'b1111, 0, 4'b0001, 8'hA0);
    step4(0, 4'b1111, 0, 4'b0010, 8'hA1);
    step4(0, 4'b1111, 0, 4'b0100, 8'hA2);
    step4(0, 4'b1111, 0, 4'b1000, 8'hA3);
    step4(0, 4'b1111, 0, 4'b0001, 8'hA0);
    // Full stall for 3 cycles, then producer 1 wins first.
    step4(0, 4'b0110, 1, 4'b0000, 8'h00);
    step4(0, 4'b0110, 1, 4'b0000, 8'h00);
    step4(0, 4'b0110, 1, 4'b0000, 8'h00);
    step4(0, 4'b0110, 0, 4'b0010, 8'hA1);
    step4(0, 4'b0110, 0, 4'b0100, 8'hA2);
    // No request leaves ptr at 3; the scan then wraps 3 -> 0.
    step4(0, 4'b0000, 0, 4'b0000, 8'h00);
    step4(0, 4'b0011, 0, 4'b0001, 8'hA0);
    step4(0, 4'b1000, 0, 4'b1000, 8'hA3);
    // Reset mid-operation, then restart from ptr = 0.
    step4(1, 4'b1100, 0, 4'b0000, 8'h00);
    step4(0, 4'b1100, 0, 4'b0100, 8'hA2);
    step4(0, 4'b1100, 0, 4'b1000, 8'hA3);
    step4(0, 4'b1100, 0, 4'b0100, 8'hA2);
`endif
    step4(0, 4'b0000, 0, 4'b0000, 8'h00);

    // ---------------- dut3 (N = 3) ----------------
    step3(1, 3'b101, 0, 3'b000, 8'h00);
    step3(0, 3'b101, 0, 3'b001, 8'h30);
    step3(0, 3'b101, 0, 3'b100, 8'h32);
    step3(0, 3'b101, 0, 3'b001, 8'h30);
    step3(0, 3'b101, 0, 3'b100, 8'h32);
    step3(0, 3'b010, 0, 3'b010, 8'h31);
    step3(0, 3'b011, 0, 3'b001, 8'h30);
    step3(0, 3'b110, 1, 3'b000, 8'h00);
    step3(0, 3'b110, 0, 3'b010, 8'h31);
    step3(0, 3'b000, 0, 3'b000, 8'h00);

    repeat (2) @(posedge clk);
    check("q4_drained", q4.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
